// File: rtl/chicken_pkg.sv
// Shared types, defaults and decode helpers for the ChickenCHACHACHA turn logic.
package chicken_pkg;

  localparam int unsigned DEF_NTILES      = 12;
  localparam int unsigned DEF_IMGW        = 3;
  localparam int unsigned DEF_TRACK_LEN   = 24;
  localparam int unsigned DEF_REVEAL_CYC  = 50000000;
  localparam int unsigned DEF_WIN_LAPS    = 1;
  localparam int unsigned DEF_TIMEOUT_CYC = 500000000;
  localparam int unsigned PW              = 5;
  localparam int unsigned LAPW            = 4;
  localparam int unsigned TW              = 32;
  localparam int unsigned NPLAYERS_MAX    = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'b000,
    ST_WAIT_FLIP = 3'b001,
    ST_REVEAL    = 3'b010,
    ST_MOVE      = 3'b011,
    ST_END_TURN  = 3'b100,
    ST_HIDE      = 3'b101,
    ST_NEXT      = 3'b110,
    ST_GAME_OVER = 3'b111
  } phase_e;

  // Player count code: 00=2, 01=3, 10=4; the unused code falls back to 2.
  function automatic logic [2:0] player_count(input logic [1:0] n);
    case (n)
      2'b00:   return 3'd2;
      2'b01:   return 3'd3;
      2'b10:   return 3'd4;
      default: return 3'd2;
    endcase
  endfunction

  // Players sit a quarter-track apart (square 6*p on the 24-square track).
  function automatic logic [PW-1:0] start_square(input logic [1:0] p,
                                                 input int unsigned track_len);
    return PW'((32'(p) * (track_len / 4)) % track_len);
  endfunction

endpackage

// File: rtl/turn_phase_fsm_phase_timer.sv
// Loadable down-counter; done_c flags the last cycle of a loaded interval.
module phase_timer
  import chicken_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          done_c
);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign done_c = (cnt_q == TW'(1));

endmodule

// File: rtl/turn_phase_fsm.sv
// Per-turn phase controller: flip, reveal, move or end turn, win detection.
// Optional flip timeout in WAIT_FLIP is enabled by defining TURN_TIMEOUT_EN.
module turn_phase_fsm
  import chicken_pkg::*;
#(
  parameter int unsigned NTILES     = DEF_NTILES,
  parameter int unsigned IMGW       = DEF_IMGW,
  parameter int unsigned TRACK_LEN  = DEF_TRACK_LEN,
  parameter int unsigned REVEAL_CYC = DEF_REVEAL_CYC,
  parameter int unsigned WIN_LAPS   = DEF_WIN_LAPS
`ifdef TURN_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        T,
  input  logic [1:0]        N,
  input  logic              flip_valid,
  input  logic [3:0]        flip_idx,
  input  logic [IMGW-1:0]   flip_img,
  input  logic [IMGW-1:0]   target_img,
  output logic [2:0]        Q,
  output logic              statecombo_next_turn,
  output logic [NTILES-1:0] revealed,
  output logic [PW-1:0]     pos_cur,
  output logic              move_pulse,
  output logic              winner_valid,
  output logic [1:0]        winner
);

  phase_e                             state_q, state_d;
  logic [NTILES-1:0]                  revealed_q, revealed_d;
  logic [NPLAYERS_MAX-1:0][PW-1:0]    pos_q, pos_d;
  logic [NPLAYERS_MAX-1:0][LAPW-1:0]  laps_q, laps_d;
  logic                               match_q, match_d;
  logic [1:0]                         winner_q, winner_d;
  logic                               move_pulse_q, move_pulse_d;
  logic                               strobe_q, strobe_d;
  logic                               winner_valid_q, winner_valid_d;

  logic              timer_load_c;
  logic [TW-1:0]     timer_val_c;
  logic              timer_done_c;
  logic              go_wait_c;
  logic              t_valid_c;
  logic [NTILES-1:0] flip_mask_c;
  logic              flip_ok_c;
  logic [PW-1:0]     pos_next_c;
  logic              wrap_c;
  logic [LAPW-1:0]   lap_next_c;

  phase_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load_c),
    .load_val (timer_val_c),
    .done_c   (timer_done_c)
  );

  assign t_valid_c   = ({1'b0, T} < player_count(N));
  assign flip_mask_c = NTILES'(1) << flip_idx;
  assign flip_ok_c   = flip_valid && (32'(flip_idx) < NTILES) &&
                       ((revealed_q & flip_mask_c) == '0);

  // Candidate square and lap count for the current player's next step.
  assign wrap_c     = (pos_q[T] == PW'(TRACK_LEN - 1));
  assign pos_next_c = wrap_c ? '0 : pos_q[T] + PW'(1);
  assign lap_next_c = (wrap_c && (laps_q[T] != '1)) ? laps_q[T] + LAPW'(1) : laps_q[T];

  always_comb begin
    state_d      = state_q;
    revealed_d   = revealed_q;
    pos_d        = pos_q;
    laps_d       = laps_q;
    match_d      = match_q;
    winner_d     = winner_q;
    timer_load_c = 1'b0;
    timer_val_c  = TW'(REVEAL_CYC);
    go_wait_c    = 1'b0;

    case (state_q)
      ST_IDLE, ST_GAME_OVER: begin
        if (start) begin
          for (int p = 0; p < NPLAYERS_MAX; p++) begin
            pos_d[p]  = start_square(2'(p), TRACK_LEN);
            laps_d[p] = '0;
          end
          revealed_d = '0;
          state_d    = ST_WAIT_FLIP;
          go_wait_c  = 1'b1;
        end
      end
      ST_WAIT_FLIP: begin
        if (&revealed_q) begin
          match_d = 1'b0;
          state_d = ST_END_TURN;
        end else if (flip_ok_c) begin
          revealed_d   = revealed_q | flip_mask_c;
          match_d      = (flip_img == target_img);
          timer_load_c = 1'b1;
          state_d      = ST_REVEAL;
`ifdef TURN_TIMEOUT_EN
        end else if (timer_done_c) begin
          match_d = 1'b0;
          state_d = ST_END_TURN;
`endif
        end
      end
      ST_REVEAL: begin
        if (timer_done_c) state_d = match_q ? ST_MOVE : ST_END_TURN;
      end
      ST_MOVE: begin
        state_d   = ST_WAIT_FLIP;
        go_wait_c = 1'b1;
        if (t_valid_c) begin
          pos_d[T]  = pos_next_c;
          laps_d[T] = lap_next_c;
          if ((32'(lap_next_c) >= WIN_LAPS) &&
              (pos_next_c == start_square(T, TRACK_LEN))) begin
            winner_d  = T;
            state_d   = ST_GAME_OVER;
            go_wait_c = 1'b0;
          end
        end
      end
      ST_END_TURN: state_d = ST_HIDE;
      ST_HIDE: begin
        revealed_d = '0;
        state_d    = ST_NEXT;
      end
      ST_NEXT: begin
        state_d   = ST_WAIT_FLIP;
        go_wait_c = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef TURN_TIMEOUT_EN
    // Every entry into WAIT_FLIP restarts the flip timeout.
    if (go_wait_c) begin
      timer_load_c = 1'b1;
      timer_val_c  = TW'(TIMEOUT_CYC);
    end
`endif

    move_pulse_d   = (state_d == ST_MOVE);
    strobe_d       = (state_d == ST_NEXT);
    winner_valid_d = (state_d == ST_GAME_OVER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      revealed_q     <= '0;
      pos_q          <= '0;
      laps_q         <= '0;
      match_q        <= 1'b0;
      winner_q       <= '0;
      move_pulse_q   <= 1'b0;
      strobe_q       <= 1'b0;
      winner_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      revealed_q     <= revealed_d;
      pos_q          <= pos_d;
      laps_q         <= laps_d;
      match_q        <= match_d;
      winner_q       <= winner_d;
      move_pulse_q   <= move_pulse_d;
      strobe_q       <= strobe_d;
      winner_valid_q <= winner_valid_d;
    end
  end

  // go_wait_c only feeds the timeout reload; keep it referenced in every build.
  logic unused_c;
  assign unused_c = go_wait_c;

  assign Q                    = state_q;
  assign statecombo_next_turn = strobe_q;
  assign revealed             = revealed_q;
  assign pos_cur              = t_valid_c ? pos_q[T] : '0;
  assign move_pulse           = move_pulse_q;
  assign winner_valid         = winner_valid_q;
  assign winner               = winner_q;

endmodule

// File: tb/tb_turn_phase_fsm.sv
// Directed bench for turn_phase_fsm with a short reveal and a 4-square track.
module tb_turn_phase_fsm;

  localparam int unsigned NTILES = 12;
  localparam int unsigned IMGW   = 3;

  logic              clk, rst_n, start, flip_valid;
  logic [1:0]        T, N;
  logic [3:0]        flip_idx;
  logic [IMGW-1:0]   flip_img, target_img;
  logic [2:0]        Q;
  logic              statecombo_next_turn, move_pulse, winner_valid;
  logic [NTILES-1:0] revealed;
  logic [4:0]        pos_cur;
  logic [1:0]        winner;

  int checks   = 0;
  int failures = 0;

  turn_phase_fsm #(
    .NTILES(NTILES), .IMGW(IMGW), .TRACK_LEN(4), .REVEAL_CYC(4), .WIN_LAPS(1)
`ifdef TURN_TIMEOUT_EN
    , .TIMEOUT_CYC(10)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .T(T), .N(N),
    .flip_valid(flip_valid), .flip_idx(flip_idx), .flip_img(flip_img),
    .target_img(target_img), .Q(Q), .statecombo_next_turn(statecombo_next_turn),
    .revealed(revealed), .pos_cur(pos_cur), .move_pulse(move_pulse),
    .winner_valid(winner_valid), .winner(winner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  task automatic flip(input logic [3:0] idx, input logic [2:0] img, input logic [2:0] tgt);
    flip_valid = 1'b1; flip_idx = idx; flip_img = img; target_img = tgt;
    @(negedge clk);
    flip_valid = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    @(negedge clk);
    checks++; if (Q !== 3'd0) begin failures++; $display("FAIL reset_q: got %0d want 0", Q); end
    checks++; if (revealed !== 12'h000) begin failures++; $display("FAIL reset_revealed: got %h want 000", revealed); end
    checks++; if (pos_cur !== 5'd0) begin failures++; $display("FAIL reset_pos: got %0d want 0", pos_cur); end
    checks++; if ({statecombo_next_turn, move_pulse, winner_valid, winner} !== 5'b0) begin
      failures++; $display("FAIL reset_outs: got %b want 00000", {statecombo_next_turn, move_pulse, winner_valid, winner});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_match;
    start = 1'b1; @(negedge clk); start = 1'b0;
    checks++; if (Q !== 3'd1) begin failures++; $display("FAIL match_start_q: got %0d want 1", Q); end
    flip(4'd3, 3'd2, 3'd2);
    checks++; if (Q !== 3'd2) begin failures++; $display("FAIL match_reveal_q: got %0d want 2", Q); end
    checks++; if (revealed !== 12'h008) begin failures++; $display("FAIL match_revealed: got %h want 008", revealed); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (Q !== 3'd2) begin failures++; $display("FAIL match_reveal_hold%0d: got %0d want 2", i, Q); end
    end
    @(negedge clk);
    checks++; if (Q !== 3'd3 || move_pulse !== 1'b1) begin
      failures++; $display("FAIL match_move: got q=%0d mp=%b want q=3 mp=1", Q, move_pulse);
    end
    @(negedge clk);
    checks++; if (Q !== 3'd1 || move_pulse !== 1'b0) begin
      failures++; $display("FAIL match_after_move: got q=%0d mp=%b want q=1 mp=0", Q, move_pulse);
    end
    checks++; if (pos_cur !== 5'd1) begin failures++; $display("FAIL match_pos: got %0d want 1", pos_cur); end
    checks++; if (revealed !== 12'h008) begin failures++; $display("FAIL match_keep_revealed: got %h want 008", revealed); end
  endtask

  task automatic test_ignored;
    flip(4'd3, 3'd2, 3'd2);
    checks++; if (Q !== 3'd1 || revealed !== 12'h008) begin
      failures++; $display("FAIL ignore_repeat: got q=%0d rev=%h want q=1 rev=008", Q, revealed);
    end
    flip(4'd13, 3'd2, 3'd2);
    checks++; if (Q !== 3'd1 || revealed !== 12'h008) begin
      failures++; $display("FAIL ignore_range: got q=%0d rev=%h want q=1 rev=008", Q, revealed);
    end
  endtask

  task automatic test_mismatch;
    flip(4'd5, 3'd1, 3'd5);
    checks++; if (Q !== 3'd2 || revealed !== 12'h028) begin
      failures++; $display("FAIL mis_reveal: got q=%0d rev=%h want q=2 rev=028", Q, revealed);
    end
    flip(4'd6, 3'd1, 3'd1);
    checks++; if (Q !== 3'd2 || revealed !== 12'h028) begin
      failures++; $display("FAIL mis_flip_in_reveal: got q=%0d rev=%h want q=2 rev=028", Q, revealed);
    end
    @(negedge clk); @(negedge clk);
    checks++; if (Q !== 3'd2) begin failures++; $display("FAIL mis_reveal_end: got %0d want 2", Q); end
    @(negedge clk);
    checks++; if (Q !== 3'd4 || statecombo_next_turn !== 1'b0) begin
      failures++; $display("FAIL mis_end_turn: got q=%0d st=%b want q=4 st=0", Q, statecombo_next_turn);
    end
    @(negedge clk);
    checks++; if (Q !== 3'd5 || statecombo_next_turn !== 1'b0 || revealed !== 12'h028) begin
      failures++; $display("FAIL mis_hide: got q=%0d st=%b rev=%h want q=5 st=0 rev=028", Q, statecombo_next_turn, revealed);
    end
    @(negedge clk);
    checks++; if (Q !== 3'd6 || statecombo_next_turn !== 1'b1 || revealed !== 12'h000) begin
      failures++; $display("FAIL mis_next: got q=%0d st=%b rev=%h want q=6 st=1 rev=000", Q, statecombo_next_turn, revealed);
    end
    @(negedge clk);
    checks++; if (Q !== 3'd1 || statecombo_next_turn !== 1'b0 || pos_cur !== 5'd1) begin
      failures++; $display("FAIL mis_back: got q=%0d st=%b pos=%0d want q=1 st=0 pos=1", Q, statecombo_next_turn, pos_cur);
    end
  endtask

`ifdef TURN_TIMEOUT_EN
  task automatic test_timeout;
    int bad;
    bad = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (Q !== 3'd1) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL to_wait: left WAIT_FLIP early in %0d cycles want 0", bad); end
    @(negedge clk);
    checks++; if (Q !== 3'd4) begin failures++; $display("FAIL to_end_turn: got %0d want 4", Q); end
    @(negedge clk); @(negedge clk);
    checks++; if (Q !== 3'd6 || statecombo_next_turn !== 1'b1) begin
      failures++; $display("FAIL to_strobe: got q=%0d st=%b want q=6 st=1", Q, statecombo_next_turn);
    end
    @(negedge clk);
  endtask
`else
  task automatic test_timeout;
    int strobes, bad;
    strobes = 0; bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (statecombo_next_turn === 1'b1) strobes++;
      if (Q !== 3'd1) bad++;
    end
    checks++; if (strobes !== 0 || bad !== 0) begin
      failures++; $display("FAIL no_timeout: got strobes=%0d offstate=%0d want 0 0", strobes, bad);
    end
  endtask
`endif

  task automatic test_start_ignored;
    start = 1'b1; @(negedge clk); start = 1'b0;
    checks++; if (Q !== 3'd1 || pos_cur !== 5'd1) begin
      failures++; $display("FAIL start_ignored: got q=%0d pos=%0d want q=1 pos=1", Q, pos_cur);
    end
  endtask

  task automatic test_reset_mid_reveal;
    flip(4'd7, 3'd3, 3'd3);
    @(negedge clk);
    checks++; if (Q !== 3'd2) begin failures++; $display("FAIL rmid_in_reveal: got %0d want 2", Q); end
    rst_n = 1'b0;
    #1;
    checks++; if (Q !== 3'd0 || revealed !== 12'h000 || pos_cur !== 5'd0 || statecombo_next_turn !== 1'b0) begin
      failures++; $display("FAIL rmid_async: got q=%0d rev=%h pos=%0d st=%b want 0 000 0 0", Q, revealed, pos_cur, statecombo_next_turn);
    end
    @(negedge clk);
    checks++; if (Q !== 3'd0 || statecombo_next_turn !== 1'b0 || move_pulse !== 1'b0) begin
      failures++; $display("FAIL rmid_hold: got q=%0d st=%b mp=%b want 0 0 0", Q, statecombo_next_turn, move_pulse);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_win;
    start = 1'b1; @(negedge clk); start = 1'b0;
    checks++; if (Q !== 3'd1 || pos_cur !== 5'd0) begin
      failures++; $display("FAIL win_start: got q=%0d pos=%0d want 1 0", Q, pos_cur);
    end
    for (int k = 0; k < 4; k++) begin
      flip(4'(k), 3'(k), 3'(k));
      repeat (4) @(negedge clk);
      checks++; if (move_pulse !== 1'b1) begin failures++; $display("FAIL win_move%0d: got mp=%b want 1", k, move_pulse); end
      @(negedge clk);
      if (k < 3) begin
        checks++; if (Q !== 3'd1 || pos_cur !== 5'(k + 1) || winner_valid !== 1'b0) begin
          failures++; $display("FAIL win_step%0d: got q=%0d pos=%0d wv=%b want q=1 pos=%0d wv=0", k, Q, pos_cur, winner_valid, k + 1);
        end
      end else begin
        checks++; if (Q !== 3'd7 || winner_valid !== 1'b1 || winner !== 2'd0 || pos_cur !== 5'd0) begin
          failures++; $display("FAIL win_over: got q=%0d wv=%b w=%0d pos=%0d want 7 1 0 0", Q, winner_valid, winner, pos_cur);
        end
      end
    end
    flip(4'd8, 3'd1, 3'd1);
    checks++; if (Q !== 3'd7 || revealed !== 12'h00F || winner_valid !== 1'b1) begin
      failures++; $display("FAIL win_flip_ignored: got q=%0d rev=%h wv=%b want 7 00f 1", Q, revealed, winner_valid);
    end
  endtask

  task automatic test_restart;
    T = 2'd1;
    start = 1'b1; @(negedge clk); start = 1'b0;
    checks++; if (Q !== 3'd1 || winner_valid !== 1'b0 || revealed !== 12'h000) begin
      failures++; $display("FAIL restart: got q=%0d wv=%b rev=%h want 1 0 000", Q, winner_valid, revealed);
    end
    checks++; if (pos_cur !== 5'd1) begin failures++; $display("FAIL restart_p1_pos: got %0d want 1", pos_cur); end
    T = 2'd2; #1;
    checks++; if (pos_cur !== 5'd0) begin failures++; $display("FAIL invalid_player_pos: got %0d want 0", pos_cur); end
    N = 2'd1; #1;
    checks++; if (pos_cur !== 5'd2) begin failures++; $display("FAIL p2_of3_pos: got %0d want 2", pos_cur); end
    T = 2'd0; N = 2'd0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; T = 2'd0; N = 2'd0;
    flip_valid = 1'b0; flip_idx = '0; flip_img = '0; target_img = '0;
    test_reset;
    test_match;
    test_ignored;
    test_mismatch;
    test_timeout;
    test_start_ignored;
    test_reset_mid_reveal;
    test_win;
    test_restart;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
